// File: rtl/granule_playout_pkg.sv
// ---------------------------------------------------------------------------
// granule_playout_pkg
// Shared definitions for the granule playout path: default granule geometry
// and the playout FSM state encoding. Also imported by the decode-side
// writer so both ends of the double buffer agree on sizes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package granule_playout_pkg;

   localparam int GRANULE_SAMPLES_DEFAULT = 576;
   localparam int GRANULE_SAMPLE_WIDTH_DEFAULT = 18;
   localparam int GRANULE_ADDR_BITS_DEFAULT = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SWITCH  = 3'd1,
      ST_FETCH   = 3'd2,
      ST_LOAD    = 3'd3,
      ST_PRESENT = 3'd4
   } playout_state_t;

endpackage

`default_nettype wire

// File: rtl/granule_playout.sv
// ---------------------------------------------------------------------------
// granule_playout
// Plays a decoded stereo granule out of the read bank of a granule double
// buffer, one sample pair at a time, with a valid/ready handshake. A
// completed granule in the write bank is remembered in a pending flag and
// switched in (one-cycle buffer_switch_event) once playout is idle or the
// current granule has been fully presented.
//
// Ports:
//   clk                    rising-edge clock
//   rst                    synchronous reset, active low
//   granule_written        pulse: a granule is complete in the write bank
//   buffer_switch_event    pulse: swap the double-buffer banks
//   granule_ch0_read_addr  channel-0 read address
//   granule_ch0_read_data  channel-0 read data (one cycle after address)
//   granule_ch1_read_addr  channel-1 read address
//   granule_ch1_read_data  channel-1 read data (one cycle after address)
//   sample_valid           stereo pair available
//   sample_ready           downstream accepts the pair
//   sample_ch0/sample_ch1  stereo pair
//   playout_busy           FSM is not idle
//   overrun                sticky: granule written before previous switched in
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module granule_playout
   import granule_playout_pkg::*;
#(
   parameter int SAMPLES_PER_GRANULE = GRANULE_SAMPLES_DEFAULT,
   parameter int SAMPLE_WIDTH        = GRANULE_SAMPLE_WIDTH_DEFAULT,
   parameter int ADDR_BITS           = GRANULE_ADDR_BITS_DEFAULT
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    granule_written,
   output logic                    buffer_switch_event,
   output logic [ADDR_BITS-1:0]    granule_ch0_read_addr,
   input  logic [SAMPLE_WIDTH-1:0] granule_ch0_read_data,
   output logic [ADDR_BITS-1:0]    granule_ch1_read_addr,
   input  logic [SAMPLE_WIDTH-1:0] granule_ch1_read_data,
   output logic                    sample_valid,
   input  logic                    sample_ready,
   output logic [SAMPLE_WIDTH-1:0] sample_ch0,
   output logic [SAMPLE_WIDTH-1:0] sample_ch1,
   output logic                    playout_busy,
   output logic                    overrun
);

   localparam logic [ADDR_BITS-1:0] LAST_INDEX = ADDR_BITS'(SAMPLES_PER_GRANULE - 1);

   playout_state_t state;
   playout_state_t next_state;

   logic                 pending;
   logic [ADDR_BITS-1:0] index;
   logic                 handshake;
   logic                 last_sample;
   logic                 enter_switch;

   assign handshake    = (state == ST_PRESENT) && sample_ready;
   assign last_sample  = (index == LAST_INDEX);
   // SWITCH never loops on itself, so next_state == SWITCH marks entry.
   assign enter_switch = (next_state == ST_SWITCH);

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (pending) begin
               next_state = ST_SWITCH;
            end
         end
         ST_SWITCH:  next_state = ST_FETCH;
         ST_FETCH:   next_state = ST_LOAD;
         ST_LOAD:    next_state = ST_PRESENT;
         ST_PRESENT: begin
            if (handshake) begin
               if (!last_sample) begin
                  next_state = ST_FETCH;
               end else if (pending) begin
                  next_state = ST_SWITCH;
               end else begin
                  next_state = ST_IDLE;
               end
            end
         end
         default:    next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state               <= ST_IDLE;
         pending             <= 1'b0;
         index               <= '0;
         overrun             <= 1'b0;
         buffer_switch_event <= 1'b0;
         sample_ch0          <= '0;
         sample_ch1          <= '0;
      end else begin
         state <= next_state;

         // Registered Moore output: high for exactly the cycle spent in SWITCH.
         buffer_switch_event <= enter_switch;

         // A new granule arriving in the same cycle the previous one is
         // consumed keeps the flag set.
         if (granule_written) begin
            pending <= 1'b1;
         end else if (enter_switch) begin
            pending <= 1'b0;
         end

         // The previous granule is still waiting unless it is being switched
         // in on this very edge.
         if (granule_written && pending && !enter_switch) begin
            overrun <= 1'b1;
         end

         if (enter_switch) begin
            index <= '0;
         end else if (handshake && !last_sample) begin
            index <= index + 1'b1;
         end

         // Read data for the address issued in FETCH is valid during LOAD.
         if (state == ST_LOAD) begin
            sample_ch0 <= granule_ch0_read_data;
            sample_ch1 <= granule_ch1_read_data;
         end
      end
   end

   assign granule_ch0_read_addr = index;
   assign granule_ch1_read_addr = index;
   assign sample_valid          = (state == ST_PRESENT);
   assign playout_busy          = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_granule_playout.sv
`default_nettype none

module tb_granule_playout;
   import granule_playout_pkg::*;

   localparam int N  = 576;
   localparam int SW = 18;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          granule_written = 1'b0;
   logic          sample_ready = 1'b0;
   logic          buffer_switch_event;
   logic [AW-1:0] a0, a1;
   logic [SW-1:0] d0, d1;
   logic          sample_valid;
   logic [SW-1:0] ch0, ch1;
   logic          busy;
   logic          overrun;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int unsigned salt;

   granule_playout dut (
      .clk                   (clk),
      .rst                   (rst),
      .granule_written       (granule_written),
      .buffer_switch_event   (buffer_switch_event),
      .granule_ch0_read_addr (a0),
      .granule_ch0_read_data (d0),
      .granule_ch1_read_addr (a1),
      .granule_ch1_read_data (d1),
      .sample_valid          (sample_valid),
      .sample_ready          (sample_ready),
      .sample_ch0            (ch0),
      .sample_ch1            (ch1),
      .playout_busy          (busy),
      .overrun               (overrun)
   );

   always #5 clk = ~clk;

   // Reference contents of the granule read bank.
   function automatic logic [SW-1:0] ref0(input int a);
      return SW'(a);
   endfunction

   function automatic logic [SW-1:0] ref1(input int a);
      int unsigned v;
      v = 32'(a) * 37 + salt;
      return v[SW-1:0];
   endfunction

   // Synchronous-read RAM model.
   always @(posedge clk) begin
      d0 <= ref0(int'(a0));
      d1 <= ref1(int'(a1));
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: handshakes and switch pulses, sampled mid-cycle.
   logic [SW-1:0] got0[$];
   logic [SW-1:0] got1[$];
   int            hs_cyc[$];
   int            last_hs_cyc[$];
   int            sw_cyc[$];

   always @(negedge clk) begin
      if (rst) begin
         if (sample_valid && sample_ready) begin
            got0.push_back(ch0);
            got1.push_back(ch1);
            hs_cyc.push_back(cyc);
            if (got0.size() % N == 0) last_hs_cyc.push_back(cyc);
         end
         if (buffer_switch_event) sw_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got0.delete();
      got1.delete();
      hs_cyc.delete();
      last_hs_cyc.delete();
      sw_cyc.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      granule_written = 1'b0;
      sample_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      clear_mon();
   endtask

   task automatic pulse_gw();
      granule_written = 1'b1;
      tick();
      granule_written = 1'b0;
   endtask

   task automatic run_until_hs(input int count, input int budget, input string name);
      int n = 0;
      sample_ready = 1'b1;
      while (got0.size() < count && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (got0.size() < count) begin
         bad++;
         $display("FAIL %s: handshakes=%0d required %0d within %0d cycles", name, got0.size(), count, budget);
      end
   endtask

   task automatic wait_sample(input int value, input int budget, input string name);
      int n = 0;
      while (!(sample_valid && ch0 == SW'(value)) && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (!(sample_valid && ch0 == SW'(value))) begin
         bad++;
         $display("FAIL %s: valid=%b ch0=%0d required valid=1 ch0=%0d", name, sample_valid, ch0, value);
      end
   endtask

   task automatic run_idle(input int budget, input bit rnd, input string name);
      int n = 0;
      int unstable = 0;
      logic pv, pr;
      logic [SW-1:0] p0, p1;
      while (busy && n < budget) begin
         sample_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
         pv = sample_valid;
         pr = sample_ready;
         p0 = ch0;
         p1 = ch1;
         tick();
         n++;
         if (pv && !pr && !(sample_valid && ch0 == p0 && ch1 == p1)) unstable++;
      end
      sample_ready = 1'b1;
      total++;
      if (busy) begin
         bad++;
         $display("FAIL %s_idle: busy=%b required 0 after %0d cycles", name, busy, budget);
      end
      if (rnd) begin
         total++;
         if (unstable != 0) begin
            bad++;
            $display("FAIL %s_stable: unstable_cycles=%0d required 0", name, unstable);
         end
      end
   endtask

   task automatic check_stream(input int granules, input string name);
      logic [SW-1:0] e0[$];
      logic [SW-1:0] e1[$];
      int first_bad = -1;
      for (int g = 0; g < granules; g++) begin
         for (int i = 0; i < N; i++) begin
            e0.push_back(ref0(i));
            e1.push_back(ref1(i));
         end
      end
      if (got0.size() == e0.size()) begin
         for (int i = 0; i < e0.size(); i++) begin
            if (first_bad < 0 && (got0[i] !== e0[i] || got1[i] !== e1[i])) first_bad = i;
         end
      end
      total++;
      if (got0.size() != e0.size()) begin
         bad++;
         $display("FAIL %s_count: pairs=%0d required %0d", name, got0.size(), e0.size());
      end else if (first_bad >= 0) begin
         bad++;
         $display("FAIL %s_data: pair %0d = %h/%h required %h/%h", name, first_bad,
                  got0[first_bad], got1[first_bad], e0[first_bad], e1[first_bad]);
      end
   endtask

   task automatic check_switches(input int expected, input string name);
      total++;
      if (sw_cyc.size() != expected) begin
         bad++;
         $display("FAIL %s_switches: pulses=%0d required %0d", name, sw_cyc.size(), expected);
      end
   endtask

   task automatic check_second_switch(input string name);
      total++;
      if (sw_cyc.size() < 2 || last_hs_cyc.size() < 1) begin
         bad++;
         $display("FAIL %s_switch_time: switches=%0d granule_ends=%0d required >=2 and >=1",
                  name, sw_cyc.size(), last_hs_cyc.size());
      end else if (sw_cyc[1] != last_hs_cyc[0] + 1) begin
         bad++;
         $display("FAIL %s_switch_time: switch at cycle %0d required %0d", name, sw_cyc[1], last_hs_cyc[0] + 1);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      logic [4+2*AW+2*SW-1:0] v;
      v = {buffer_switch_event, sample_valid, busy, overrun, a0, a1, ch0, ch1};
      total++;
      if (v !== '0) begin
         bad++;
         $display("FAIL %s: outputs=%h required all zero", name, v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (4) begin
         granule_written = 1'($urandom_range(1));
         sample_ready = 1'($urandom_range(1));
         tick();
      end
      check_reset_outputs("reset_values");
      granule_written = 1'b0;
      rst = 1'b1;
      clear_mon();
      repeat (6) tick();
      total++;
      if (busy !== 1'b0 || sw_cyc.size() != 0) begin
         bad++;
         $display("FAIL reset_no_pending: busy=%b switches=%0d required 0/0", busy, sw_cyc.size());
      end
   endtask

   task automatic test_single();
      do_reset();
      granule_written = 1'b1;
      tick();
      granule_written = 1'b0;
      total++;
      if (buffer_switch_event !== 1'b0) begin
         bad++;
         $display("FAIL single_t1: switch=%b required 0", buffer_switch_event);
      end
      tick();
      total++;
      if (buffer_switch_event !== 1'b1 || busy !== 1'b1 || sample_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_t2: switch/busy/valid=%b%b%b required 110", buffer_switch_event, busy, sample_valid);
      end
      tick();
      tick();
      total++;
      if (sample_valid !== 1'b0 || buffer_switch_event !== 1'b0 || a0 !== '0 || a1 !== '0) begin
         bad++;
         $display("FAIL single_t4: valid=%b switch=%b addr=%0d/%0d required 0 0 0/0",
                  sample_valid, buffer_switch_event, a0, a1);
      end
      tick();
      total++;
      if (sample_valid !== 1'b1 || ch0 !== ref0(0) || ch1 !== ref1(0)) begin
         bad++;
         $display("FAIL single_t5: valid=%b ch=%h/%h required 1 %h/%h", sample_valid, ch0, ch1, ref0(0), ref1(0));
      end
      run_idle(N * 3 + 20, 1'b0, "single");
      check_stream(1, "single");
      check_switches(1, "single");
      total++;
      if (hs_cyc.size() != N || hs_cyc[N-1] - hs_cyc[0] != 3 * (N - 1)) begin
         bad++;
         $display("FAIL single_rate: handshakes=%0d span=%0d required %0d span %0d",
                  hs_cyc.size(), (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] - hs_cyc[0] : 0, N, 3 * (N - 1));
      end
   endtask

   task automatic test_backpressure();
      int held_bad = 0;
      do_reset();
      pulse_gw();
      wait_sample(7, 100, "bp_reach7");
      sample_ready = 1'b0;
      repeat (10) begin
         tick();
         if (!(sample_valid === 1'b1 && ch0 === ref0(7) && ch1 === ref1(7))) held_bad++;
      end
      total++;
      if (held_bad != 0) begin
         bad++;
         $display("FAIL bp_hold: cycles_changed=%0d required 0 (valid=%b ch0=%0d)", held_bad, sample_valid, ch0);
      end
      sample_ready = 1'b1;
      tick();
      wait_sample(8, 10, "bp_next8");
      total++;
      if (ch1 !== ref1(8)) begin
         bad++;
         $display("FAIL bp_ch1: ch1=%h required %h", ch1, ref1(8));
      end
      run_idle(N * 3 + 20, 1'b0, "bp");
      check_stream(1, "bp");
   endtask

   task automatic test_random_ready();
      do_reset();
      pulse_gw();
      tick();
      run_idle(N * 20, 1'b1, "random");
      check_stream(1, "random");
      check_switches(1, "random");
   endtask

   task automatic test_back_to_back();
      do_reset();
      pulse_gw();
      run_until_hs(100, N * 4, "b2b_mid");
      pulse_gw();
      run_idle(2 * N * 3 + 50, 1'b0, "b2b");
      check_stream(2, "b2b");
      check_switches(2, "b2b");
      check_second_switch("b2b");
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL b2b_overrun: overrun=%b required 0", overrun);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      pulse_gw();
      run_until_hs(50, N * 4, "ovr_a");
      pulse_gw();
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL ovr_first: overrun=%b required 0", overrun);
      end
      run_until_hs(200, N * 4, "ovr_b");
      pulse_gw();
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL ovr_second: overrun=%b required 1", overrun);
      end
      run_idle(2 * N * 3 + 50, 1'b1, "ovr");
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL ovr_sticky: overrun=%b required 1", overrun);
      end
      check_switches(2, "ovr");
      check_stream(2, "ovr");
   endtask

   task automatic test_simultaneous();
      do_reset();
      granule_written = 1'b1;
      tick();
      tick();
      granule_written = 1'b0;
      total++;
      if (buffer_switch_event !== 1'b1) begin
         bad++;
         $display("FAIL simul_switch: switch=%b required 1", buffer_switch_event);
      end
      run_idle(2 * N * 3 + 50, 1'b0, "simul");
      check_switches(2, "simul");
      check_second_switch("simul");
      check_stream(2, "simul");
   endtask

   task automatic test_reset_mid();
      int sw_before;
      do_reset();
      pulse_gw();
      wait_sample(300, N * 4, "mid_reach300");
      rst = 1'b0;
      tick();
      check_reset_outputs("mid_reset_values");
      rst = 1'b1;
      sw_before = sw_cyc.size();
      repeat (50) begin
         sample_ready = 1'($urandom_range(1));
         tick();
      end
      sample_ready = 1'b1;
      total++;
      if (sw_cyc.size() != sw_before || busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_quiet: new_switches=%0d busy=%b required 0/0", sw_cyc.size() - sw_before, busy);
      end
      clear_mon();
      pulse_gw();
      tick();
      total++;
      if (buffer_switch_event !== 1'b1) begin
         bad++;
         $display("FAIL mid_restart: switch=%b required 1", buffer_switch_event);
      end
      run_idle(N * 3 + 20, 1'b0, "mid");
      check_stream(1, "mid");
   endtask

   initial begin
      salt = $urandom;
      test_reset();
      test_single();
      test_backpressure();
      test_random_ready();
      test_back_to_back();
      test_overrun();
      test_simultaneous();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
